// File: rtl/alu_seq_if.sv
// alu_seq_if: handshake and data bundle for the sequential ALU.
//
// Signals:
//   in_valid / in_ready   - operand transfer handshake (producer -> ALU)
//   a, b                  - WIDTH-bit operands
//   op                    - OPW-bit operation code
//   out_valid / out_ready - result transfer handshake (ALU -> consumer)
//   out                   - WIDTH-bit registered result
//   zero, neg, carry, ovf - registered flags describing out
//
// Modports:
//   master - the side that issues operations and consumes results
//   slave  - the ALU itself
`timescale 1ns/1ps
interface alu_seq_if #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, out, zero, neg, carry, ovf
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, out, zero, neg, carry, ovf
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready handshake on both sides.
//
// Single-cycle ops (ADD, SUB, AND, XOR, OR, PASSB, SLL, SRL, SRA, SLT and
// undefined codes) present their result on the edge after acceptance and can
// stream at one op per cycle while the consumer keeps out_ready high.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   defined   - opcode 10 runs an iterative shift-add multiply (one multiplier
//               bit per cycle, WIDTH cycles) and returns the low WIDTH bits.
//   undefined - opcode 10 is an undefined op (result 0) and no multiplier
//               state or datapath exists.
//
// Ports:
//   clk   - clock, rising-edge active
//   rst_n - asynchronous active-low reset
//   bus   - alu_seq_if.slave: in_valid/in_ready/a/b/op in,
//           out_valid/out_ready/out/zero/neg/carry/ovf out
`timescale 1ns/1ps
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [OPW-1:0] OP_ADD   = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(1);
    localparam logic [OPW-1:0] OP_AND   = OPW'(2);
    localparam logic [OPW-1:0] OP_XOR   = OPW'(3);
    localparam logic [OPW-1:0] OP_OR    = OPW'(4);
    localparam logic [OPW-1:0] OP_PASSB = OPW'(5);
    localparam logic [OPW-1:0] OP_SLL   = OPW'(6);
    localparam logic [OPW-1:0] OP_SRL   = OPW'(7);
    localparam logic [OPW-1:0] OP_SRA   = OPW'(8);
    localparam logic [OPW-1:0] OP_SLT   = OPW'(9);
`ifdef ALU_SEQ_MUL_EN
    localparam logic [OPW-1:0] OP_MUL   = OPW'(10);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1
`ifdef ALU_SEQ_MUL_EN
        ,
        MUL_BUSY = 2'd2
`endif
    } state_e;

    state_e           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_q;
    logic             zero_q;
    logic             neg_q;
    logic             carry_q;
    logic             ovf_q;

    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             ovf_d;
    logic             in_ready;
    logic             accept;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [SHW-1:0]   shamt;

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [SHW-1:0]   cnt_q;

    // Partial product for the multiplier bit currently at the LSB.
    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    // The extra top bit of the extended add/sub is the carry-out; for SUB it
    // is the borrow, so it gets inverted to give carry = (a >= b).
    assign sum_ext  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff_ext = {1'b0, bus.a} - {1'b0, bus.b};
    assign shamt    = bus.b[SHW-1:0];

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                res_d   = sum_ext[WIDTH-1:0];
                carry_d = sum_ext[WIDTH];
                ovf_d   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                res_d   = diff_ext[WIDTH-1:0];
                carry_d = ~diff_ext[WIDTH];
                ovf_d   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (diff_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:   res_d = bus.a & bus.b;
            OP_XOR:   res_d = bus.a ^ bus.b;
            OP_OR:    res_d = bus.a | bus.b;
            OP_PASSB: res_d = bus.b;
            OP_SLL:   res_d = bus.a << shamt;
            OP_SRL:   res_d = bus.a >> shamt;
            OP_SRA:   res_d = $signed(bus.a) >>> shamt;
            OP_SLT:   res_d = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default:  res_d = '0;
        endcase
    end

    // A pending result blocks new input until the consumer takes it, which
    // is what lets HOLD stream one op per cycle when out_ready stays high.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            HOLD:    in_ready = bus.out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            zero_q      <= 1'b1;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                        if (bus.op == OP_MUL) begin
                            mcand_q     <= bus.a;
                            mplier_q    <= bus.b;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            out_valid_q <= 1'b0;
                            state_q     <= MUL_BUSY;
                        end else
`endif
                        begin
                            out_q       <= res_d;
                            zero_q      <= (res_d == '0);
                            neg_q       <= res_d[WIDTH-1];
                            carry_q     <= carry_d;
                            ovf_q       <= ovf_d;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end
                    end else if (bus.out_ready) begin
                        // Result taken with nothing new queued: out keeps its value.
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                MUL_BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        out_q       <= acc_d;
                        zero_q      <= (acc_d == '0);
                        neg_q       <= acc_d[WIDTH-1];
                        carry_q     <= 1'b0;
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
`endif
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=16, OPW=4).
// Expected results come from an arithmetic reference model and are queued
// when an operation is accepted; a monitor compares them whenever the DUT
// presents a result. Follows ALU_SEQ_MUL_EN the same way the design does.
`timescale 1ns/1ps
module tb_alu_seq;

    localparam int W  = 16;
    localparam int OW = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W), .OPW(OW)) bus ();

    alu_seq #(.WIDTH(W), .OPW(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  flags;
    } exp_t;

    exp_t expQ[$];
    int   checks    = 0;
    int   errors    = 0;
    bit   randReady = 1'b0;

    logic [15:0] corners [4] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: flags packed as {zero, neg, carry, ovf}.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic [3:0] o);
        exp_t        e;
        int          sx = $signed(x);
        int          sy = $signed(y);
        int          sh = int'(y) % 16;
        int          s;
        int          u;
        longint      p;
        logic [15:0] r = 16'h0000;
        logic        c = 1'b0;
        logic        v = 1'b0;
        case (o)
            4'd0: begin
                u = int'(x) + int'(y);
                r = u[15:0];
                c = (u > 65535);
                s = sx + sy;
                v = (s > 32767) || (s < -32768);
            end
            4'd1: begin
                u = int'(x) - int'(y);
                r = u[15:0];
                c = (x >= y);
                s = sx - sy;
                v = (s > 32767) || (s < -32768);
            end
            4'd2: r = x & y;
            4'd3: r = x ^ y;
            4'd4: r = x | y;
            4'd5: r = y;
            4'd6: r = x << sh;
            4'd7: r = x >> sh;
            4'd8: begin
                s = sx >>> sh;
                r = s[15:0];
            end
            4'd9: r = (sx < sy) ? 16'd1 : 16'd0;
`ifdef ALU_SEQ_MUL_EN
            4'd10: begin
                p = longint'(x) * longint'(y);
                r = p[15:0];
            end
`endif
            default: r = 16'h0000;
        endcase
        e.res   = r;
        e.flags = {(r == 16'h0000), r[15], c, v};
        return e;
    endfunction

    // Scoreboard monitor: compares the head expectation whenever a result is
    // shown, and retires it only when the handshake completes.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected: got out=0x%0h, expected no result at %0t", bus.out, $time);
            end else begin
                checkOutput("sb_out", 32'(bus.out), 32'(expQ[0].res));
                checkOutput("sb_flags", 32'({bus.zero, bus.neg, bus.carry, bus.ovf}), 32'(expQ[0].flags));
                if (bus.out_ready) void'(expQ.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (randReady) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Presents one op from posedge+1 until accepted; returns at posedge+1
    // after the accepting edge with the operands scrambled.
    task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb, input logic [3:0] top,
                                 output int stalls);
        stalls       = 0;
        bus.a        = ta;
        bus.b        = tb;
        bus.op       = top;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && stalls <= 300) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls > 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0, expected acceptance at %0t", $time);
        end else begin
            expQ.push_back(model(ta, tb, top));
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.op       = 4'($urandom_range(0, 15));
    endtask

    task automatic drainOutputs();
        int n = 0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        while ((expQ.size() != 0 || bus.out_valid) && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d results pending, expected 0", expQ.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directOp(input string name, input logic [15:0] ta, input logic [15:0] tb,
                            input logic [3:0] top, input logic [15:0] eRes, input logic [3:0] eFlags);
        int st;
        bus.out_ready = 1'b1;
        applyStimulus(ta, tb, top, st);
        checkOutput({name, "_stall"}, 32'(st), 32'd0);
        @(negedge clk);
        checkOutput({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({name, "_out"}, 32'(bus.out), 32'(eRes));
        checkOutput({name, "_flags"}, 32'({bus.zero, bus.neg, bus.carry, bus.ovf}), 32'(eFlags));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          st;
        int          low;
        logic [15:0] ra;
        logic [15:0] rb;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        bus.out_ready = 1'b0;
        $display("[TB] start");

        repeat (3) @(negedge clk);
        checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out", 32'(bus.out), 32'd0);
        checkOutput("rst_flags", 32'({bus.zero, bus.neg, bus.carry, bus.ovf}), 32'b1000);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        directOp("add_ovf", 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 4'b0101);
        directOp("add_carry", 16'hFFFF, 16'h0001, 4'd0, 16'h0000, 4'b1010);
        directOp("sub_eq", 16'd5, 16'd5, 4'd1, 16'h0000, 4'b1010);
        directOp("sub_neg", 16'd3, 16'd5, 4'd1, 16'hFFFE, 4'b0100);
        directOp("sub_ovf", 16'h8000, 16'h0001, 4'd1, 16'h7FFF, 4'b0011);
        directOp("slt", 16'hFFFF, 16'h0001, 4'd9, 16'h0001, 4'b0000);
        directOp("sll", 16'h0003, 16'h0014, 4'd6, 16'h0030, 4'b0000);
        directOp("undef", 16'h1234, 16'h5678, 4'd15, 16'h0000, 4'b1000);

        // Back-to-back stream: one accept and one result per cycle.
        bus.out_ready = 1'b1;
        applyStimulus(16'hA5A5, 16'h0FF0, 4'd3, st);
        checkOutput("b2b_stall0", 32'(st), 32'd0);
        checkOutput("b2b_valid0", 32'(bus.out_valid), 32'd1);
        applyStimulus(16'h1200, 16'h0034, 4'd4, st);
        checkOutput("b2b_stall1", 32'(st), 32'd0);
        checkOutput("b2b_valid1", 32'(bus.out_valid), 32'd1);
        applyStimulus(16'h8000, 16'h0003, 4'd8, st);
        checkOutput("b2b_stall2", 32'(st), 32'd0);
        @(negedge clk);
        checkOutput("b2b_sra", 32'(bus.out), 32'hF000);
        @(posedge clk);
        #1;

        // Consumer stall: result must hold and no new op may enter.
        drainOutputs();
        bus.out_ready = 1'b0;
        applyStimulus(16'hF0F0, 16'h3C3C, 4'd2, st);
        bus.a        = 16'd1;
        bus.b        = 16'd1;
        bus.op       = 4'd0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("stall_out", 32'(bus.out), 32'h3030);
            checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("stall_consumed_once", 32'(bus.out_valid), 32'd0);
        checkOutput("stall_out_kept", 32'(bus.out), 32'h3030);
        @(posedge clk);
        #1;

`ifdef ALU_SEQ_MUL_EN
        drainOutputs();
        applyStimulus(16'd300, 16'd300, 4'd10, st);
        low = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            checkOutput("mul_busy_valid", 32'(bus.out_valid), 32'd0);
            low++;
        end
        checkOutput("mul_busy_cycles", 32'(low), 32'd16);
        checkOutput("mul_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("mul_out", 32'(bus.out), 32'h5F90);
        @(posedge clk);
        #1;
`else
        low = 0;
        directOp("op10_undef", 16'd300, 16'd300, 4'd10, 16'h0000, 4'b1000);
`endif

        // Reset in the middle of an operation: nothing may come out.
        drainOutputs();
        directOp("pre_rst", 16'h00AA, 16'h0F0F, 4'd3, 16'h0FA5, 4'b0000);
`ifdef ALU_SEQ_MUL_EN
        applyStimulus(16'd300, 16'd300, 4'd10, st);
`else
        bus.out_ready = 1'b0;
        applyStimulus(16'h1234, 16'h0F0F, 4'd2, st);
`endif
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_out", 32'(bus.out), 32'd0);
        checkOutput("midrst_flags", 32'({bus.zero, bus.neg, bus.carry, bus.ovf}), 32'b1000);
        expQ.delete();
        #1 rst_n = 1'b1;
        directOp("post_rst", 16'h0100, 16'h0023, 4'd0, 16'h0123, 4'b0000);

        // Randomized traffic with a randomly stalling consumer.
        randReady = 1'b1;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
                rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
                applyStimulus(ra, rb, 4'($urandom_range(0, 15)), st);
            end
        end
        randReady = 1'b0;
        drainOutputs();
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits (WIDTH >= 4).
REQ-002 Parameter OPW, default 4, opcode width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand/op presented this cycle.
REQ-006 in_ready  output  1  block accepts a transfer when in_valid && in_ready at the rising edge.
REQ-007 a, b  input  WIDTH each  first and second operands.
REQ-008 op  input  OPW  operation code.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes the result when out_valid && out_ready at the rising edge.
REQ-011 out  output  WIDTH  registered result.
REQ-012 zero, neg, carry, ovf  output  1 each  registered flags for out.

Function
REQ-013 Opcodes SHALL be: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 XOR; 4 OR; 5 PASSB b; 6 SLL a<<b[log2 WIDTH-1:0]; 7 SRL logical; 8 SRA arithmetic; 9 SLT signed a<b -> 1 else 0; 10 MUL low WIDTH bits of a*b (unsigned); all other codes -> out 0.
REQ-014 zero SHALL be 1 iff out == 0, for every opcode including the undefined ones.
REQ-015 neg SHALL equal out[WIDTH-1].
REQ-016 carry SHALL be the carry-out of ADD, the inverted borrow of SUB (1 when a >= b unsigned), and 0 for all other ops.
REQ-017 ovf SHALL be set on signed overflow of ADD/SUB only, 0 otherwise.
REQ-018 FSM states SHALL be IDLE, MUL_BUSY, HOLD.
REQ-019 IDLE: in_ready = 1; non-MUL accept loads out/flags next edge, out_valid = 1, goes to HOLD; MUL accept goes to MUL_BUSY.
REQ-020 MUL_BUSY: in_ready = 0; iterative shift-add, one multiplier bit per cycle, WIDTH cycles; on the last cycle load out/flags, set out_valid, go to HOLD.
REQ-021 HOLD: out, flags, out_valid SHALL stay stable until out_ready = 1; in_ready = out_ready.
REQ-022 HOLD with out_ready = 1 and in_valid = 1 (non-MUL): new result loads the same edge, remains HOLD (throughput 1 op/cycle).
REQ-023 HOLD with out_ready = 1 and in_valid = 1 (MUL): out_valid drops, go to MUL_BUSY.
REQ-024 HOLD with out_ready = 1 and in_valid = 0: out_valid drops, go to IDLE; out keeps last value.
REQ-025 Latency SHALL be 1 cycle (accept edge to out_valid) for non-MUL ops and WIDTH+1 cycles for MUL.
REQ-026 Operands SHALL be captured at accept; later changes on a, b, op SHALL not affect an in-flight op.
REQ-027 Shift amounts >= WIDTH cannot occur (amount is masked to log2 WIDTH bits).

Reset
REQ-028 rst_n = 0 SHALL immediately force state IDLE, out_valid 0, out 0, zero 1, neg 0, carry 0, ovf 0, and clear the multiplier accumulator and counter.
REQ-029 Reset during MUL_BUSY SHALL abort the multiply with no result emitted.
REQ-030 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro ALU_SEQ_MUL_EN: when defined, opcode 10 SHALL behave per REQ-020/025.
REQ-032 Without ALU_SEQ_MUL_EN, opcode 10 SHALL be an undefined op (out 0, zero 1, 1-cycle latency), MUL_BUSY and the multiplier datapath SHALL not exist, and in_ready SHALL never drop in IDLE.

Verification
REQ-033 WIDTH=16: ADD a=0x7FFF b=0x0001, out_ready=1 -> next cycle out=0x8000, ovf=1, neg=1, carry=0, zero=0.
REQ-034 SUB a=5 b=5 -> out=0, zero=1, carry=1; SLT a=0xFFFF b=1 -> out=1.
REQ-035 MUL a=300 b=300 (macro on) -> in_ready low 16 cycles, out_valid at cycle 17, out=0x5F90 (90000 mod 65536).
REQ-036 Back-to-back XOR/OR/SRA every cycle, out_ready=1 -> one result per cycle, correct order; SRA a=0x8000 b=3 -> 0xF000.
REQ-037 out_ready held 0 for 5 cycles after a result -> out/flags stable, in_ready=0, no input accepted; release -> result consumed once.
REQ-038 rst_n pulsed low at MUL cycle 8 -> out_valid=0, out=0, zero=1 immediately; next op after reset completes normally.
